// File: rtl/namuru_dump_sequencer.sv
// Drains correlator accumulations on each accum_int rising edge: reads status and
// new-data flags, clears them, then streams a header plus I/Q pairs for every flagged channel.
module namuru_dump_sequencer #(
    parameter int NCH = 12
) (
    input  logic        correlator_clk,
    input  logic        correlator_rst,
    input  logic        enable,
    input  logic        accum_int,
    output logic        reg_req,
    output logic        reg_we,
    output logic [7:0]  reg_adr,
    output logic [31:0] reg_wdat,
    input  logic        reg_ack,
    input  logic [31:0] reg_rdat,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        overrun,
    input  logic        overrun_clr,
    output logic [15:0] frame_count
);

    typedef enum logic [3:0] {
        IDLE, RD_STAT, RD_ND, WR_CLR, SCAN, HDR, RD_LO, RD_HI, EMIT, DONE
    } state_t;

    state_t         state;
    logic           accum_int_d;
    logic           rise;
    logic [1:0]     stat;
    logic [NCH-1:0] mask;
    logic [NCH-1:0] mask_rest;
    logic [3:0]     ch;
    logic [3:0]     ch_next;
    logic [1:0]     pair;
    logic [15:0]    i_word;
    logic [7:0]     pair_adr;
    logic           unused_rdat;

    function automatic logic [3:0] lowest_set(input logic [NCH-1:0] m);
        logic [3:0] idx;
        idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (m[k]) idx = 4'(k);
        end
        return idx;
    endfunction

    assign rise        = accum_int & ~accum_int_d;
    assign ch_next     = lowest_set(mask);
    assign mask_rest   = mask & ~(NCH'(1) << ch);
    // I word of the current pair; Q sits at the next word address
    assign pair_adr    = {ch, 4'h0} + 8'd4 + {5'b0, pair, 1'b0};
    assign busy        = (state != IDLE);
    assign unused_rdat = ^reg_rdat[31:16];

    always_ff @(posedge correlator_clk) begin
        if (correlator_rst) begin
            state       <= IDLE;
            accum_int_d <= 1'b0;
            reg_req     <= 1'b0;
            reg_we      <= 1'b0;
            reg_adr     <= '0;
            reg_wdat    <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            overrun     <= 1'b0;
            frame_count <= '0;
            stat        <= '0;
            mask        <= '0;
            ch          <= '0;
            pair        <= '0;
            i_word      <= '0;
        end else begin
            accum_int_d <= accum_int;
            if (rise && state != IDLE)
                overrun <= 1'b1;
            else if (overrun_clr)
                overrun <= 1'b0;

            // A register state raises reg_req on its first cycle, so every
            // transaction is preceded by at least one idle cycle on the port.
            case (state)
                IDLE: if (enable && rise) state <= RD_STAT;
                RD_STAT: begin
                    if (!reg_req) begin
                        reg_req <= 1'b1;
                        reg_we  <= 1'b0;
                        reg_adr <= 8'hE0;
                    end else if (reg_ack) begin
                        reg_req <= 1'b0;
                        stat    <= reg_rdat[1:0];
                        state   <= RD_ND;
                    end
                end
                RD_ND: begin
                    if (!reg_req) begin
                        reg_req <= 1'b1;
                        reg_we  <= 1'b0;
                        reg_adr <= 8'hE1;
                    end else if (reg_ack) begin
                        reg_req <= 1'b0;
                        mask    <= reg_rdat[NCH-1:0];
                        state   <= WR_CLR;
                    end
                end
                WR_CLR: begin
                    if (!reg_req) begin
                        reg_req  <= 1'b1;
                        reg_we   <= 1'b1;
                        reg_adr  <= 8'hE4;
                        reg_wdat <= 32'h3;
                    end else if (reg_ack) begin
                        reg_req <= 1'b0;
                        reg_we  <= 1'b0;
                        state   <= SCAN;
                    end
                end
                SCAN: begin
                    if (mask == '0) begin
                        state <= DONE;
                    end else begin
                        ch        <= ch_next;
                        out_valid <= 1'b1;
                        out_data  <= {8'hC5, 2'b00, stat, ch_next, frame_count};
                        state     <= HDR;
                    end
                end
                HDR: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        pair      <= 2'd0;
                        state     <= RD_LO;
                    end
                end
                RD_LO: begin
                    if (!reg_req) begin
                        reg_req <= 1'b1;
                        reg_we  <= 1'b0;
                        reg_adr <= pair_adr;
                    end else if (reg_ack) begin
                        reg_req <= 1'b0;
                        i_word  <= reg_rdat[15:0];
                        state   <= RD_HI;
                    end
                end
                RD_HI: begin
                    if (!reg_req) begin
                        reg_req <= 1'b1;
                        reg_we  <= 1'b0;
                        reg_adr <= pair_adr + 8'd1;
                    end else if (reg_ack) begin
                        reg_req   <= 1'b0;
                        out_valid <= 1'b1;
                        out_data  <= {i_word, reg_rdat[15:0]};
                        out_last  <= (pair == 2'd2) && (mask_rest == '0);
                        state     <= EMIT;
                    end
                end
                EMIT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (pair == 2'd2) begin
                            mask  <= mask_rest;
                            state <= SCAN;
                        end else begin
                            pair  <= pair + 2'd1;
                            state <= RD_LO;
                        end
                    end
                end
                DONE: begin
                    frame_count <= frame_count + 16'd1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_namuru_dump_sequencer.sv
// Bench for namuru_dump_sequencer: register-port responder, stream sink and a
// frame-level reference model built from the flag/mask rules.
`timescale 1ns/1ps
module tb_namuru_dump_sequencer;
    localparam int NCH = 12;

    logic        correlator_clk;
    logic        correlator_rst;
    logic        enable;
    logic        accum_int;
    logic        reg_req;
    logic        reg_we;
    logic [7:0]  reg_adr;
    logic [31:0] reg_wdat;
    logic        reg_ack;
    logic [31:0] reg_rdat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        overrun;
    logic        overrun_clr;
    logic [15:0] frame_count;

    namuru_dump_sequencer #(.NCH(NCH)) dut (
        .correlator_clk(correlator_clk), .correlator_rst(correlator_rst),
        .enable(enable), .accum_int(accum_int),
        .reg_req(reg_req), .reg_we(reg_we), .reg_adr(reg_adr), .reg_wdat(reg_wdat),
        .reg_ack(reg_ack), .reg_rdat(reg_rdat),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .overrun(overrun), .overrun_clr(overrun_clr), .frame_count(frame_count)
    );

    initial correlator_clk = 1'b0;
    always #5 correlator_clk = ~correlator_clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [256];
    logic [32:0] got_w[$];
    logic [32:0] exp_w[$];
    logic [40:0] got_t[$];
    logic [40:0] exp_t[$];
    logic [15:0] exp_fc;

    int rd_lat = 1;
    int wr_lat = 1;
    bit rand_lat = 0;
    bit ready_rand = 0;
    int stall_at = -1;
    int stall_cnt = 0;
    int word_idx = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Register responder: programmable ack latency, stray acks while idle.
    initial begin : responder
        int req_cnt;
        int cur_lat;
        logic [40:0] first_sig;
        reg_ack = 1'b0;
        reg_rdat = '0;
        req_cnt = 0;
        cur_lat = 1;
        first_sig = '0;
        forever begin
            @(negedge correlator_clk);
            reg_ack = 1'b0;
            if (reg_req === 1'b1) begin
                if (req_cnt == 0) begin
                    first_sig = {reg_we, reg_adr, reg_wdat};
                    cur_lat = rand_lat ? int'($urandom_range(1, 4)) : (reg_we ? wr_lat : rd_lat);
                end
                req_cnt++;
                if (req_cnt >= cur_lat) begin
                    chk("reg_stable", {reg_we, reg_adr, reg_wdat}, first_sig);
                    reg_ack = 1'b1;
                    reg_rdat = reg_we ? $urandom : mem[reg_adr];
                    got_t.push_back({reg_we, reg_adr, reg_we ? reg_wdat : 32'h0});
                    req_cnt = 0;
                end
            end else begin
                req_cnt = 0;
                reg_ack = 1'($urandom_range(0, 1));
                reg_rdat = $urandom;
            end
        end
    end

    // Stream sink: collects accepted words, checks holding while stalled.
    initial begin : sink
        bit pend;
        bit stalling;
        logic [32:0] pend_w;
        pend = 0;
        pend_w = '0;
        out_ready = 1'b0;
        forever begin
            @(negedge correlator_clk);
            if (pend) chk("out_hold", {out_valid, out_last, out_data}, {1'b1, pend_w});
            stalling = (out_valid === 1'b1) && (word_idx == stall_at) && (stall_cnt < 10);
            if (stalling) begin
                stall_cnt++;
                out_ready = 1'b0;
                chk("stall_no_req", reg_req, 1'b0);
            end else begin
                out_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            if (out_valid === 1'b1 && out_ready) begin
                got_w.push_back({out_last, out_data});
                word_idx++;
                pend = 0;
            end else begin
                pend = (out_valid === 1'b1);
                pend_w = {out_last, out_data};
            end
        end
    end

    task automatic load_mem(input logic [NCH-1:0] m, input logic [1:0] s);
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        mem[8'hE0][1:0] = s;
        mem[8'hE1][NCH-1:0] = m;
    endtask

    // Expected frame: header + three I/Q words per flagged channel, ascending.
    task automatic build_expect(input logic [31:0] nd_raw, input logic [31:0] st_raw, input logic [15:0] fc);
        logic [NCH-1:0] m;
        logic [7:0] a;
        int last_ch;
        m = nd_raw[NCH-1:0];
        exp_w.delete();
        exp_t.delete();
        exp_t.push_back({1'b0, 8'hE0, 32'h0});
        exp_t.push_back({1'b0, 8'hE1, 32'h0});
        exp_t.push_back({1'b1, 8'hE4, 32'h3});
        last_ch = -1;
        for (int c = 0; c < NCH; c++) if (m[c]) last_ch = c;
        for (int c = 0; c < NCH; c++) begin
            if (m[c]) begin
                exp_w.push_back({1'b0, 8'hC5, 2'b00, st_raw[1:0], 4'(c), fc});
                for (int p = 0; p < 3; p++) begin
                    a = 8'(c * 16 + 4 + 2 * p);
                    exp_t.push_back({1'b0, a, 32'h0});
                    exp_t.push_back({1'b0, a + 8'd1, 32'h0});
                    exp_w.push_back({(c == last_ch) && (p == 2), mem[a][15:0], mem[a + 8'd1][15:0]});
                end
            end
        end
    endtask

    task automatic start_frame(input logic [NCH-1:0] m, input logic [1:0] s);
        load_mem(m, s);
        build_expect(mem[8'hE1], mem[8'hE0], exp_fc);
        got_w.delete();
        got_t.delete();
        word_idx = 0;
        stall_cnt = 0;
        @(negedge correlator_clk);
        accum_int = 1'b1;
        @(negedge correlator_clk);
        accum_int = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        while (busy !== 1'b0 && t < 20000) begin
            @(negedge correlator_clk);
            t++;
        end
        chk({tag, "/done_in_time"}, t < 20000, 1'b1);
    endtask

    task automatic check_frame(input string tag);
        int n;
        chk({tag, "/nwords"}, got_w.size(), exp_w.size());
        n = (got_w.size() < exp_w.size()) ? got_w.size() : exp_w.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s/word%0d", tag, i), got_w[i], exp_w[i]);
        chk({tag, "/ntxn"}, got_t.size(), exp_t.size());
        n = (got_t.size() < exp_t.size()) ? got_t.size() : exp_t.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s/txn%0d", tag, i), got_t[i], exp_t[i]);
        exp_fc = exp_fc + 16'd1;
        chk({tag, "/frame_count"}, frame_count, exp_fc);
    endtask

    task automatic run_frame(input string tag, input logic [NCH-1:0] m, input logic [1:0] s);
        start_frame(m, s);
        wait_done(tag);
        check_frame(tag);
    endtask

    initial begin : main
        int t;
        correlator_rst = 1'b1;
        enable = 1'b0;
        accum_int = 1'b0;
        overrun_clr = 1'b0;
        exp_fc = '0;
        for (int i = 0; i < 256; i++) mem[i] = '0;
        repeat (3) @(negedge correlator_clk);
        chk("rst/reg_port", {reg_req, reg_we, reg_adr, reg_wdat}, '0);
        chk("rst/stream", {out_valid, out_last, out_data}, '0);
        chk("rst/status", {busy, overrun, frame_count}, '0);
        correlator_rst = 1'b0;
        enable = 1'b1;
        @(negedge correlator_clk);

        rd_lat = 3; wr_lat = 1;
        run_frame("t1", 12'h001, 2'b10);

        rd_lat = 1;
        run_frame("t2", 12'h805, 2'($urandom));

        stall_at = 2;
        run_frame("t3", 12'h010, 2'b01);
        chk("t3/stall_len", stall_cnt, 10);
        stall_at = -1;

        // second edge mid-frame, with overrun_clr in the same cycle; enable dropped later
        start_frame(12'h0C0, 2'b11);
        repeat (15) @(negedge correlator_clk);
        accum_int = 1'b1;
        overrun_clr = 1'b1;
        @(negedge correlator_clk);
        accum_int = 1'b0;
        overrun_clr = 1'b0;
        repeat (10) @(negedge correlator_clk);
        enable = 1'b0;
        wait_done("t4");
        check_frame("t4");
        chk("t4/overrun_set", overrun, 1'b1);
        enable = 1'b1;
        repeat (5) @(negedge correlator_clk);
        chk("t4/no_restart", {busy, frame_count}, {1'b0, exp_fc});
        overrun_clr = 1'b1;
        @(negedge correlator_clk);
        overrun_clr = 1'b0;
        chk("t4/overrun_clr", overrun, 1'b0);

        enable = 1'b0;
        @(negedge correlator_clk);
        accum_int = 1'b1;
        @(negedge correlator_clk);
        accum_int = 1'b0;
        repeat (5) @(negedge correlator_clk);
        chk("t4/disabled_edge", {busy, overrun, frame_count}, {1'b0, 1'b0, exp_fc});
        enable = 1'b1;

        run_frame("t5", 12'h000, 2'b01);

        force dut.frame_count = 16'hFFFE;
        @(negedge correlator_clk);
        release dut.frame_count;
        exp_fc = 16'hFFFE;
        run_frame("t5wrap_a", 12'h000, 2'b00);
        run_frame("t5wrap_b", 12'h200, 2'b10);

        rand_lat = 1;
        ready_rand = 1;
        for (int k = 0; k < 6; k++) run_frame($sformatf("rnd%0d", k), NCH'($urandom), 2'($urandom));
        rand_lat = 0;
        ready_rand = 0;

        rd_lat = 3;
        start_frame(12'h001, 2'b01);
        t = 0;
        while (!(reg_req === 1'b1 && reg_adr === 8'h05) && t < 500) begin
            @(negedge correlator_clk);
            t++;
        end
        chk("t6/reach_rd_hi", t < 500, 1'b1);
        correlator_rst = 1'b1;
        @(negedge correlator_clk);
        chk("t6/reg_port", {reg_req, reg_we, reg_adr, reg_wdat}, '0);
        chk("t6/stream", {out_valid, out_last, out_data}, '0);
        chk("t6/status", {busy, overrun, frame_count}, '0);
        correlator_rst = 1'b0;
        exp_fc = '0;
        @(negedge correlator_clk);
        run_frame("t6_restart", 12'h003, 2'b10);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
